// File: rtl/instr_memory_pkg.sv
// Shared bus definitions for the execute -> memory -> writeback pipeline.
// Field positions and struct layouts are reused by instr_execute and the writeback stage.
package instr_memory_pkg;

  localparam int EXEBUS_W = 72;
  localparam int MEMBUS_W = 71;

  localparam int EXE_WRITEREG_LSB  = 0;
  localparam int EXE_WRITEREG_MSB  = 4;
  localparam int EXE_WRITEDATA_LSB = 5;
  localparam int EXE_WRITEDATA_MSB = 36;
  localparam int EXE_ALUOUT_LSB    = 37;
  localparam int EXE_ALUOUT_MSB    = 68;
  localparam int EXE_MEMWRITE_BIT  = 69;
  localparam int EXE_MEMTOREG_BIT  = 70;
  localparam int EXE_REGWRITE_BIT  = 71;

  localparam int MEM_WRITEREG_LSB  = 0;
  localparam int MEM_WRITEREG_MSB  = 4;
  localparam int MEM_ALUOUT_LSB    = 5;
  localparam int MEM_ALUOUT_MSB    = 36;
  localparam int MEM_READDATA_LSB  = 37;
  localparam int MEM_READDATA_MSB  = 68;
  localparam int MEM_MEMTOREG_BIT  = 69;
  localparam int MEM_REGWRITE_BIT  = 70;

  // Members are listed MSB first so a cast from the flat bus lines up with the constants above.
  typedef struct packed {
    logic        regWrite;
    logic        memtoReg;
    logic        memWrite;
    logic [31:0] aluOut;
    logic [31:0] writeData;
    logic [4:0]  writeReg;
  } exebus_t;

  typedef struct packed {
    logic        regWriteWb;
    logic        memtoRegWb;
    logic [31:0] readDataWb;
    logic [31:0] aluOutWb;
    logic [4:0]  writeRegWb;
  } membus_t;

endpackage

// File: rtl/instr_memory_if.sv
// Execute-to-memory bundle: the incoming exebus, the outgoing membus and the MEM-stage forwarding wires.
interface instr_memory_if;
  import instr_memory_pkg::*;

  logic [EXEBUS_W-1:0] exebus;
  logic [MEMBUS_W-1:0] membus;
  logic                regWriteMem;
  logic [4:0]          writeRegMem;
  logic [31:0]         aluOutMem;
  logic                alignFault;

  modport master (
    output exebus,
    input  membus, regWriteMem, writeRegMem, aluOutMem, alignFault
  );

  modport slave (
    input  exebus,
    output membus, regWriteMem, writeRegMem, aluOutMem, alignFault
  );

endinterface

// File: rtl/instr_memory_data_mem.sv
// Word-addressed data memory: single port, synchronous write, asynchronous read.
// INIT_ZERO only affects the power-up value seen in simulation; reset never clears the array.
module data_mem #(
  parameter int DEPTH_LOG2 = 6,
  parameter int INIT_ZERO  = 1
) (
  input  logic                  clock,
  input  logic                  i_writeEn,
  input  logic [DEPTH_LOG2-1:0] i_index,
  input  logic [31:0]           i_writeData,
  output logic [31:0]           o_readData
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] r_mem [DEPTH] = '{default: (INIT_ZERO != 0) ? 32'h0 : 32'hx};

  always_ff @(posedge clock) begin
    if (i_writeEn) begin
      r_mem[i_index] <= i_writeData;
    end
  end

  assign o_readData = r_mem[i_index];

endmodule

// File: rtl/instr_memory.sv
// MEM stage: performs the exebus load/store, registers membus for writeback, drives forwarding.
// Define MEM_ALIGN_CHECK_EN to trap misaligned memory accesses into a sticky alignFault flag.
module instr_memory
  import instr_memory_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int INIT_ZERO  = 1
) (
  input  logic           clock,
  input  logic           reset,
  instr_memory_if.slave  memIf
);

  exebus_t                 w_exe;
  logic [DEPTH_LOG2-1:0]   w_index;
  logic [31:0]             w_readData;
  logic                    w_misaligned;
  logic                    w_storeEn;
  membus_t                 r_membus;

  assign w_exe   = exebus_t'(memIf.exebus);
  assign w_index = w_exe.aluOut[DEPTH_LOG2+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = (w_exe.memWrite | w_exe.memtoReg) & (w_exe.aluOut[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_storeEn = w_exe.memWrite & ~reset & ~w_misaligned;

  data_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_ZERO  (INIT_ZERO)
  ) u_dataMem (
    .clock       (clock),
    .i_writeEn   (w_storeEn),
    .i_index     (w_index),
    .i_writeData (w_exe.writeData),
    .o_readData  (w_readData)
  );

  // Read data is sampled before the store lands, so a combined store+load sees the old word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_membus <= '0;
    end else begin
      r_membus.regWriteWb <= w_exe.regWrite & ~w_misaligned;
      r_membus.memtoRegWb <= w_exe.memtoReg;
      r_membus.readDataWb <= w_readData;
      r_membus.aluOutWb   <= w_exe.aluOut;
      r_membus.writeRegWb <= w_exe.writeReg;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic r_alignFault;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_alignFault <= 1'b0;
    end else if (w_misaligned) begin
      r_alignFault <= 1'b1;
    end
  end

  assign memIf.alignFault = r_alignFault;
`else
  assign memIf.alignFault = 1'b0;
`endif

  assign memIf.membus      = r_membus;
  assign memIf.regWriteMem = w_exe.regWrite;
  assign memIf.writeRegMem = w_exe.writeReg;
  assign memIf.aluOutMem   = w_exe.aluOut;

endmodule

// File: tb/tb_instr_memory.sv
// Directed bench for instr_memory: reset, store/load, wrap, forwarding, back-to-back, illegal encoding, alignment.
// Expected membus values are hand-built as {regWrite, memtoReg, readData, aluOut, writeReg}.
module tb_instr_memory;
  import instr_memory_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  instr_memory_if memIf ();

  instr_memory #(
    .DEPTH_LOG2 (6),
    .INIT_ZERO  (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .memIf (memIf.slave)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic rw, input logic mt, input logic mw,
                               input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] wr);
    @(negedge clock);
    memIf.exebus = {rw, mt, mw, alu, wd, wr};
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    logic [70:0] exp;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
      tick();
      checks++;
      if (memIf.membus !== 71'h0) begin
        failures++;
        $display("[TB] FAIL reset_membus cycle %0d: got %h expected %h", i, memIf.membus, 71'h0);
      end
    end
    checks++;
    if (memIf.alignFault !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_alignFault: got %b expected 0", memIf.alignFault);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd1);
    reset = 1'b0;
    tick();
    exp = {1'b1, 1'b1, 32'h0, 32'h10, 5'd1};
    checks++;
    if (memIf.membus !== exp) begin
      failures++;
      $display("[TB] FAIL reset_store_dropped: got %h expected %h", memIf.membus, exp);
    end
  endtask

  task automatic test_store_load;
    logic [70:0] exp;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 5'd0);
    tick();
    exp = {1'b0, 1'b0, 32'h0, 32'h20, 5'd0};
    checks++;
    if (memIf.membus !== exp) begin
      failures++;
      $display("[TB] FAIL store_membus: got %h expected %h", memIf.membus, exp);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd9);
    tick();
    exp = {1'b1, 1'b1, 32'h12345678, 32'h20, 5'd9};
    checks++;
    if (memIf.membus !== exp) begin
      failures++;
      $display("[TB] FAIL load_after_store: got %h expected %h", memIf.membus, exp);
    end
  endtask

  task automatic test_wrap;
    logic [70:0] exp;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 32'hA5A5A5A5, 5'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 5'd2);
    tick();
    exp = {1'b1, 1'b1, 32'hA5A5A5A5, 32'h0, 5'd2};
    checks++;
    if (memIf.membus !== exp) begin
      failures++;
      $display("[TB] FAIL wrap_load: got %h expected %h", memIf.membus, exp);
    end
  endtask

  task automatic test_forwarding;
    logic [70:0] exp;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd3);
    #1;
    checks++;
    if (memIf.regWriteMem !== 1'b1 || memIf.writeRegMem !== 5'd3 || memIf.aluOutMem !== 32'h55) begin
      failures++;
      $display("[TB] FAIL forwarding: got rw=%b wr=%0d alu=%h expected rw=1 wr=3 alu=00000055",
               memIf.regWriteMem, memIf.writeRegMem, memIf.aluOutMem);
    end
    tick();
    exp = {1'b1, 1'b0, 32'h0, 32'h55, 5'd3};
    checks++;
    if (memIf.membus !== exp) begin
      failures++;
      $display("[TB] FAIL rtype_passthrough: got %h expected %h", memIf.membus, exp);
    end
    checks++;
    if (memIf.alignFault !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rtype_unaligned_fault: got %b expected 0", memIf.alignFault);
    end
  endtask

  task automatic test_back_to_back;
    logic [70:0] exp;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h4, 32'h1, 5'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h4, 32'h2, 5'd0);
    tick();
    exp = {1'b0, 1'b0, 32'h1, 32'h4, 5'd0};
    checks++;
    if (memIf.membus !== exp) begin
      failures++;
      $display("[TB] FAIL b2b_second_store: got %h expected %h", memIf.membus, exp);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 5'd7);
    tick();
    exp = {1'b1, 1'b1, 32'h2, 32'h4, 5'd7};
    checks++;
    if (memIf.membus !== exp) begin
      failures++;
      $display("[TB] FAIL b2b_load: got %h expected %h", memIf.membus, exp);
    end
  endtask

  task automatic test_illegal_encoding;
    logic [70:0] exp;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h30, 32'h77, 5'd4);
    tick();
    exp = {1'b1, 1'b1, 32'h0, 32'h30, 5'd4};
    checks++;
    if (memIf.membus !== exp) begin
      failures++;
      $display("[TB] FAIL illegal_old_data: got %h expected %h", memIf.membus, exp);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 5'd4);
    tick();
    exp = {1'b1, 1'b1, 32'h77, 32'h30, 5'd4};
    checks++;
    if (memIf.membus !== exp) begin
      failures++;
      $display("[TB] FAIL illegal_store_done: got %h expected %h", memIf.membus, exp);
    end
  endtask

  task automatic test_reset_midop;
    logic [70:0] exp;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 32'hCAFE, 5'd0);
    reset = 1'b1;
    tick();
    checks++;
    if (memIf.membus !== 71'h0) begin
      failures++;
      $display("[TB] FAIL midop_reset_membus: got %h expected %h", memIf.membus, 71'h0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd5);
    reset = 1'b0;
    tick();
    exp = {1'b1, 1'b1, 32'h0, 32'h40, 5'd5};
    checks++;
    if (memIf.membus !== exp) begin
      failures++;
      $display("[TB] FAIL midop_store_dropped: got %h expected %h", memIf.membus, exp);
    end
  endtask

  task automatic test_align;
    logic [70:0] exp;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h22, 32'hFFFF, 5'd6);
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    exp = {1'b0, 1'b0, 32'h12345678, 32'h22, 5'd6};
`else
    exp = {1'b1, 1'b0, 32'h12345678, 32'h22, 5'd6};
`endif
    checks++;
    if (memIf.membus !== exp) begin
      failures++;
      $display("[TB] FAIL align_store_membus: got %h expected %h", memIf.membus, exp);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    checks++;
`ifdef MEM_ALIGN_CHECK_EN
    if (memIf.alignFault !== 1'b1) begin
      failures++;
      $display("[TB] FAIL align_fault_held: got %b expected 1", memIf.alignFault);
    end
`else
    if (memIf.alignFault !== 1'b0) begin
      failures++;
      $display("[TB] FAIL align_fault_tied: got %b expected 0", memIf.alignFault);
    end
`endif
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd8);
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    exp = {1'b1, 1'b1, 32'h12345678, 32'h20, 5'd8};
`else
    exp = {1'b1, 1'b1, 32'h0000FFFF, 32'h20, 5'd8};
`endif
    checks++;
    if (memIf.membus !== exp) begin
      failures++;
      $display("[TB] FAIL align_word_contents: got %h expected %h", memIf.membus, exp);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (memIf.alignFault !== 1'b0) begin
      failures++;
      $display("[TB] FAIL align_fault_reset: got %b expected 0", memIf.alignFault);
    end
  endtask

  initial begin
    memIf.exebus = '0;
    test_reset();
    test_store_load();
    test_wrap();
    test_forwarding();
    test_back_to_back();
    test_illegal_encoding();
    test_reset_midop();
    test_align();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
